// File: rtl/gate_sequencer_pkg.sv
// Shared definitions for the gate sequencer: op encodings, FSM states, default width.
// No logic here; constants and types only.
// Imported by the interface, the gate unit and the top.
package gate_sequencer_pkg;

   localparam int WIDTH_DEF = 8;

   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_XOR  = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;  // behaves as AND

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/gate_sequencer_if.sv
// Request/status bundle between a controller and the gate sequencer.
// Pure wiring; no latency of its own.
// No backpressure: start is sampled only while the sequencer is idle.
interface gate_sequencer_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             abort;
   logic [1:0]       op;
   logic [WIDTH-1:0] data;
   logic             busy;
   logic             done;
   logic             result;

   modport master (
      output start, abort, op, data,
      input  busy, done, result
   );

   modport slave (
      input  start, abort, op, data,
      output busy, done, result
   );
endinterface

// File: rtl/gate_sequencer_gate_unit.sv
// Single shared 2-input gate, function selected by op.
// Combinational, zero latency.
// No flow control.
module gate_unit
   import gate_sequencer_pkg::*;
(
   input  logic       a_i,
   input  logic       b_i,
   input  logic [1:0] op_i,
   output logic       y_o
);

   // Reserved encoding falls into the AND branch on purpose.
   always_comb begin
      y_o = a_i & b_i;
      case (op_i)
         OP_OR:          y_o = a_i | b_i;
         OP_XOR:         y_o = a_i ^ b_i;
         OP_AND,
         OP_RSVD:        y_o = a_i & b_i;
         default:        y_o = a_i & b_i;
      endcase
   end

endmodule

// File: rtl/gate_sequencer.sv
// Bit-serial reduction (AND/OR/XOR) of a WIDTH-bit operand through one shared gate.
// Latency: start edge E0, done/result valid after edge E(WIDTH-1), done drops at E(WIDTH).
// No queuing: start is ignored outside IDLE; abort cancels a run without touching result.
module gate_sequencer
   import gate_sequencer_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic            clk,
   input  logic            resetn,
   gate_sequencer_if.slave bus
);

   localparam int             IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0]  IDX_LAST = IW'(WIDTH - 1);

   state_t           state_q,  state_d;
   logic [WIDTH-1:0] data_q,   data_d;
   logic [1:0]       op_q,     op_d;
   logic             acc_q,    acc_d;
   logic [IW-1:0]    idx_q,    idx_d;
   logic             result_q, result_d;
   logic             gate_y;

   // The one gate instance: folds the next captured operand bit into the accumulator.
   gate_unit u_gate (
      .a_i  (acc_q),
      .b_i  (data_q[idx_q]),
      .op_i (op_q),
      .y_o  (gate_y)
   );

   // State register; reset clears the whole datapath, including the held result.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         data_q   <= '0;
         op_q     <= '0;
         acc_q    <= 1'b0;
         idx_q    <= '0;
         result_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         idx_q    <= idx_d;
         result_q <= result_d;
      end
   end

   // Next-state and datapath updates; everything holds unless a branch says otherwise.
   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      op_d     = op_q;
      acc_d    = acc_q;
      idx_d    = idx_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            // start wins over abort here; abort only matters in RUN.
            if (bus.start) begin
               data_d  = bus.data;
               op_d    = bus.op;
               acc_d   = bus.data[0];
               idx_d   = IW'(1);
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (bus.abort) begin
               state_d = ST_IDLE;
            end else begin
               acc_d = gate_y;
               if (idx_q == IDX_LAST) begin
                  // Last bit: publish and hold idx at its ceiling.
                  result_d = gate_y;
                  state_d  = ST_DONE;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Status is decoded from state only, result straight from its register.
   assign bus.busy   = (state_q == ST_RUN);
   assign bus.done   = (state_q == ST_DONE);
   assign bus.result = result_q;

endmodule

// File: doc/gate_sequencer.md
GATE_SEQUENCER -- requirements
Module: gate_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand bit count; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a reduction; sampled only in IDLE.
REQ-005 The block SHALL have port abort, input, 1 bit: synchronous cancel of a run in progress.
REQ-006 The block SHALL have port op, input, 2 bits: 00 AND, 01 OR, 10 XOR, 11 reserved (executes as AND).
REQ-007 The block SHALL have port data, input, WIDTH bits: operand vector to reduce; captured with start.
REQ-008 The block SHALL have port busy, output, 1 bit: high in RUN.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse, high only in DONE.
REQ-010 The block SHALL have port result, output, 1 bit: reduction result; holds its value until the next completed run.

Function
REQ-011 The block SHALL time-share one 2-input gate unit to compute result = data[0] op data[1] op ... op data[WIDTH-1], one bit per cycle.
REQ-012 The block SHALL have states IDLE, RUN and DONE.
REQ-013 IDLE with start=1 SHALL transition on that edge as follows: capture data and op into internal registers, set acc=data[0] and idx=1, and go to RUN.
REQ-014 IDLE with start=0 SHALL remain in IDLE.
REQ-015 On each RUN edge, the block SHALL perform acc <= gate(acc, data_q[idx]) and idx <= idx+1.
REQ-016 On the RUN edge where idx==WIDTH-1, the block SHALL load the final value into result and go to DONE.
REQ-017 DONE SHALL return to IDLE unconditionally on the next edge.
REQ-018 Latency: the start edge is E0; result SHALL be valid and done high after edge E(WIDTH-1); done SHALL drop at E(WIDTH).
REQ-019 start asserted in RUN or DONE SHALL be ignored and not queued; a start held high continuously re-triggers from IDLE.
REQ-020 abort=1 in RUN SHALL force IDLE on that edge; result SHALL keep its previous value and done SHALL not pulse.
REQ-021 abort in IDLE or DONE SHALL have no effect.
REQ-022 When start and abort are both high in IDLE, start SHALL win.
REQ-023 Changes to data or op after the start edge SHALL NOT affect the run in progress.
REQ-024 idx SHALL be $clog2(WIDTH) bits wide and SHALL never exceed WIDTH-1; there is no wrap-around in RUN.

Reset
REQ-025 resetn=0 SHALL immediately force state to IDLE and clear busy, done, result, acc, idx, data_q and op_q to 0, regardless of clock.
REQ-026 Reset asserted mid-run SHALL discard the run; after release the block SHALL accept start on the first edge.

Structure
REQ-027 A shared package SHALL hold the op encodings (OP_AND, OP_OR, OP_XOR, OP_RSVD), the state enum, and the WIDTH default.
REQ-028 The single sub-module SHALL be gate_unit: a purely combinational 2-input gate selected by op, instantiated exactly once.
REQ-029 Outputs SHALL be registered or decoded from state only, with no combinational path from inputs to outputs.

Verification (WIDTH=8)
REQ-030 Directed test: op=AND, data=8'hFF, start pulse -> done at E7, result=1; busy high for 7 cycles.
REQ-031 Directed test: op=AND, data=8'hFE -> result=0; then op=OR, data=8'h00 -> result=0; then op=OR, data=8'h80 -> result=1.
REQ-032 Directed test: op=XOR, data=8'hA7 (five ones) -> result=1; op=11, data=8'hFF -> result=1 (AND behaviour).
REQ-033 Directed test: complete a run with result=1, then start a new run with data=8'h00, op=OR, and assert abort at E3 -> IDLE at E3, no done pulse, result stays 1.
REQ-034 Directed test: start held high for 20 cycles, op=AND, data=8'hFF -> two done pulses, at E7 and E16; start in RUN ignored.
REQ-035 Directed test: resetn low at E4 of a run -> busy, done and result go 0 immediately, without waiting for a clock edge; after release, a start with data=8'hFF and op=AND completes normally, returning result=1.
